mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 8x8 array multiplier, `multiplier_8bit`, between NREQ requesters. Each requester offers an operand pair over a valid/ready handshake. The block grants one requester at a time, registers its operands, and drives the multiplier from those registers. It returns the 16-bit product with the requester's ID over a single valid/ready response port. It sits between the multiplier datapath and the client blocks that need products.

---
 rtl/mult_arb_pkg.sv | 14 +
 rtl/multiplier_8bit.sv | 27 ++
 rtl/mult_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mult_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared constants and state encoding for the round-robin multiplier arbiter.
package mult_arb_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_MUL2 = 2'd2,
        S_RESP = 2'd3
    } arb_state_t;

endpackage

// File: rtl/multiplier_8bit.sv
// Combinational unsigned 8x8 array multiplier: one shifted partial product
// per bit of b, summed into a full-width 16-bit result (no truncation).
module multiplier_8bit
    import mult_arb_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] o
);

    logic [PROD_W-1:0] sum_s;

    // Accumulate the partial-product rows of the array.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < OP_W; i++) begin
            if (b[i]) begin
                sum_s = sum_s + (PROD_W'(a) << i);
            end else begin
                sum_s = sum_s;
            end
        end
    end

    assign o = sum_s;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one multiplier_8bit between NREQ
// requesters. One transaction is in flight at a time: IDLE grants and
// captures operands, MUL registers the product, RESP holds the result until
// the consumer accepts it.
// Build option: define MULT_ARB_PIPE_EN to add the MUL2 state and a second
// product register, cutting the multiplier-to-response path (latency 3).
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*OP_W-1:0]   req_a,
    input  logic [NREQ*OP_W-1:0]   req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [PROD_W-1:0]      rsp_prod,
    output logic [IDW-1:0]         rsp_id
);

    // Returns {found, index}: the first set bit of valid scanning upward
    // from start and wrapping modulo NREQ. The scan runs from the farthest
    // offset down so the nearest requester is the last (winning) write.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  start);
        logic [IDW:0] result;
        int           idx;
        result = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % NREQ;
            if (valid[idx]) begin
                result = {1'b1, IDW'(idx)};
            end
        end
        return result;
    endfunction

    arb_state_t          state_r;
    arb_state_t          state_next_s;
    logic [IDW-1:0]      ptr_r;
    logic [IDW-1:0]      ptr_next_s;
    logic [IDW-1:0]      id_r;
    logic [OP_W-1:0]     op_a_r;
    logic [OP_W-1:0]     op_b_r;
    logic [PROD_W-1:0]   prod_r;
    logic [PROD_W-1:0]   mul_o_s;
    logic [IDW:0]        pick_s;
    logic                pick_valid_s;
    logic [IDW-1:0]      pick_idx_s;
    logic [OP_W-1:0]     sel_a_s;
    logic [OP_W-1:0]     sel_b_s;
    logic [NREQ-1:0]     grant_s;
    logic                load_s;

    assign pick_s       = rr_pick(req_valid, ptr_r);
    assign pick_valid_s = pick_s[IDW];
    assign pick_idx_s   = pick_s[IDW-1:0];
    assign sel_a_s      = req_a[int'(pick_idx_s) * OP_W +: OP_W];
    assign sel_b_s      = req_b[int'(pick_idx_s) * OP_W +: OP_W];

    // Pointer moves one past the winner so the winner has lowest priority next.
    always_comb begin
        if (pick_idx_s == IDW'(NREQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = pick_idx_s + IDW'(1);
        end
    end

    // The shared multiplier only ever sees the captured operands.
    multiplier_8bit u_mul (
        .a (op_a_r),
        .b (op_b_r),
        .o (mul_o_s)
    );

    // Next-state decode and grant generation; grants only ever occur in IDLE.
    always_comb begin
        state_next_s = state_r;
        grant_s      = '0;
        load_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (pick_valid_s) begin
                    grant_s[pick_idx_s] = 1'b1;
                    load_s              = 1'b1;
                    state_next_s        = S_MUL;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_MUL: begin
`ifdef MULT_ARB_PIPE_EN
                state_next_s = S_MUL2;
`else
                state_next_s = S_RESP;
`endif
            end
            S_MUL2: begin
`ifdef MULT_ARB_PIPE_EN
                state_next_s = S_RESP;
`else
                // Unreachable without pipelining; recover to IDLE.
                state_next_s = S_IDLE;
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_RESP;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Grant is suppressed while reset is asserted so nothing looks accepted.
    always_comb begin
        if (rst) begin
            req_ready = '0;
        end else begin
            req_ready = grant_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Capture the granted requester's operands, ID and advance the pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_r <= '0;
            op_b_r <= '0;
            id_r   <= '0;
            ptr_r  <= '0;
        end else if (load_s) begin
            op_a_r <= sel_a_s;
            op_b_r <= sel_b_s;
            id_r   <= pick_idx_s;
            ptr_r  <= ptr_next_s;
        end
    end

`ifdef MULT_ARB_PIPE_EN
    logic [PROD_W-1:0] prod_pipe_r;

    // Two-stage product capture: multiplier output in MUL, response copy in MUL2.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_pipe_r <= '0;
            prod_r      <= '0;
        end else begin
            if (state_r == S_MUL) begin
                prod_pipe_r <= mul_o_s;
            end
            if (state_r == S_MUL2) begin
                prod_r <= prod_pipe_r;
            end
        end
    end
`else
    // Single-stage product capture in MUL.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_r <= '0;
        end else if (state_r == S_MUL) begin
            prod_r <= mul_o_s;
        end
    end
`endif

    // Response fields come straight from registers and stay put through RESP.
    assign rsp_valid = (state_r == S_RESP);
    assign rsp_prod  = prod_r;
    assign rsp_id    = id_r;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: stimulus pushes expected {id, product}
// on each grant; a negedge monitor pops and compares on every accepted response.
module tb_mult_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
`ifdef MULT_ARB_PIPE_EN
    localparam int LAT  = 3;
`else
    localparam int LAT  = 2;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*8-1:0]   req_a;
    logic [NREQ*8-1:0]   req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [15:0]         rsp_prod;
    logic [IDW-1:0]      rsp_id;

    int                  total = 0;
    int                  bad   = 0;
    logic [IDW+15:0]     exp_q[$];

    mult_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_prod  (rsp_prod),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic set_req(input int idx, input logic [7:0] a, input logic [7:0] b);
        req_a[idx*8 +: 8] = a;
        req_b[idx*8 +: 8] = b;
    endtask

    task automatic push_exp(input int id, input logic [15:0] prod);
        logic [IDW-1:0] id_v;
        id_v = IDW'(id);
        exp_q.push_back({id_v, prod});
    endtask

    // Called at a grant negedge: walk to the RESP negedge, no grants allowed meanwhile.
    task automatic run_txn(input bit drop);
        for (int j = 0; j < LAT; j++) begin
            step();
            if (drop && j == 0) req_valid = '0;
            samp();
            check("busy_no_grant", 32'(req_ready), 32'h0);
        end
    endtask

    // Called at a grant negedge: count cycles until rsp_valid, bounded.
    task automatic wait_valid(input bit drop, input string name);
        int cyc;
        cyc = 0;
        do begin
            step();
            if (drop && cyc == 0) req_valid = '0;
            cyc++;
            samp();
        end while (!rsp_valid && cyc < 20);
        check(name, 32'(cyc), 32'(LAT));
    endtask

    // Scoreboard monitor: every accepted response must match the queue head.
    always @(negedge clk) begin
        logic [IDW+15:0] e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got id=%0d prod=0x%0h expected no response", rsp_id, rsp_prod);
            end else begin
                e = exp_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e[IDW+15:16]));
                check("rsp_prod", 32'(rsp_prod), 32'(e[15:0]));
            end
        end
    end

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset state
        step();
        step();
        samp();
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_prod", 32'(rsp_prod), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);

        // T1: 0xFF*0xFF from requester 0
        step();
        rst       = 1'b0;
        set_req(0, 8'hFF, 8'hFF);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        samp();
        check("t1_grant", 32'(req_ready), 32'h1);
        push_exp(0, 16'hFE01);
        wait_valid(1'b1, "t1_latency");

        // T2: all requesters, rsp_ready high, ptr starts at 0 after reset
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'd3);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            samp();
            check("t2_grant", 32'(req_ready), 32'h1 << (k % NREQ));
            push_exp(k % NREQ, 16'((k % NREQ + 1) * 3));
            run_txn(k == 4);
        end

        // T3: hold rsp_ready low for 5 RESP cycles (ptr = 1)
        step();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        samp();
        check("t3_grant", 32'(req_ready), 32'h2);
        push_exp(1, 16'd6);
        run_txn(1'b0);
        for (int h = 0; h < 5; h++) begin
            if (h > 0) begin
                step();
                samp();
            end
            check("t3_hold_valid", 32'(rsp_valid), 32'h1);
            check("t3_hold_prod", 32'(rsp_prod), 32'd6);
            check("t3_hold_id", 32'(rsp_id), 32'd1);
            check("t3_hold_no_grant", 32'(req_ready), 32'h0);
        end
        step();
        rsp_ready = 1'b1;
        samp();
        step();
        samp();
        check("t3_next_grant_ptr", 32'(req_ready), 32'h4);
        push_exp(2, 16'd9);
        run_txn(1'b1);

        // T4: requester 2 changes operands and drops while 1 is served (ptr = 3)
        step();
        set_req(1, 8'h00, 8'hAB);
        set_req(2, 8'h55, 8'h11);
        req_valid = 4'b0110;
        samp();
        check("t4_grant", 32'(req_ready), 32'h2);
        push_exp(1, 16'h0000);
        step();
        req_valid = 4'b0000;
        set_req(2, 8'h77, 8'h22);
        samp();
        check("t4_busy_no_grant", 32'(req_ready), 32'h0);
        for (int j = 1; j < LAT; j++) begin
            step();
            samp();
            check("t4_busy_no_grant", 32'(req_ready), 32'h0);
        end
        step();
        samp();
        check("t4_no_grant_to_2", 32'(req_ready), 32'h0);
        check("t4_idle_rsp_valid", 32'(rsp_valid), 32'h0);

        // T5: reset during MUL discards the transaction (ptr = 2)
        step();
        set_req(0, 8'h05, 8'h07);
        req_valid = 4'b0001;
        samp();
        check("t5_grant", 32'(req_ready), 32'h1);
        step();
        rst       = 1'b1;
        req_valid = '0;
        samp();
        check("t5_rst_ready", 32'(req_ready), 32'h0);
        check("t5_rst_valid", 32'(rsp_valid), 32'h0);
        step();
        rst = 1'b0;
        set_req(3, 8'h10, 8'h10);
        req_valid = 4'b1000;
        samp();
        check("t5_first_idle_grant", 32'(req_ready), 32'h8);
        push_exp(3, 16'h0100);
        run_txn(1'b1);

        // T6: reset returns ptr to 0; 0x80*0x02 latency check
        step();
        set_req(2, 8'h01, 8'h01);
        req_valid = 4'b0100;
        samp();
        check("t6_grant", 32'(req_ready), 32'h4);
        step();
        rst       = 1'b1;
        req_valid = '0;
        samp();
        step();
        rst = 1'b0;
        set_req(0, 8'h80, 8'h02);
        set_req(3, 8'h11, 8'h11);
        req_valid = 4'b1001;
        samp();
        check("t6_ptr_after_rst", 32'(req_ready), 32'h1);
        push_exp(0, 16'h0100);
        wait_valid(1'b1, "t6_latency");
        step();
        samp();
        check("end_rsp_valid", 32'(rsp_valid), 32'h0);
        check("end_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
